bf16_div_seq: RTL and testbench
===============================

BF16_DIV_SEQ -- requirements
Module: bf16_div_seq

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 clock; rst in 1 reset; in_valid in 1 operands valid; in_ready out 1 idle, can accept; flp_a in 16 bfloat16 dividend; flp_b in 16 bfloat16 divisor; out_valid out 1 result valid; out_ready in 1 consumer accepts; quot out 16 bfloat16 quotient; flags out 4 {invalid, div_by_zero, overflow, underflow}.
REQ-002 SHALL use one clock, clk, and a synchronous, active-high reset, rst; all state updates on rising clk.
REQ-003 SHALL have parameters: BIAS, default 127, exponent bias; ITER, default 9, quotient bits produced.

Function
REQ-004 SHALL run FSM states IDLE, DIV, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-005 SHALL accept operands on an edge with in_valid&&in_ready, registering flp_a, flp_b, sign=a[15]^b[15], and exp_tmp=ea-eb+BIAS, 10-bit signed.
REQ-006 SHALL, for normal operands, go IDLE->DIV with counter=0.
REQ-007 SHALL, in DIV, do one restoring step per cycle on divisor {1,mb} and partial remainder from {1,ma}, shifting one quotient bit into q[8:0], MSB first.
REQ-008 SHALL leave DIV for NORM on the edge completing step ITER-1; accept-to-out_valid latency is exactly 10 cycles.
REQ-009 SHALL, in NORM: if q[8]=1, mantissa=q[7:1]; else mantissa=q[6:0] and exp_tmp decrements by 1; no rounding (truncate).
REQ-010 SHALL, in NORM: if exp_tmp>=255, quot={sign,8'hFF,7'h0}, overflow=1; if exp_tmp<=0, quot={sign,15'h0}, underflow=1 (no subnormals); then go to DONE.
REQ-011 SHALL treat exponent 0 as zero (mantissa ignored) and exponent 8'hFF as inf/NaN.
REQ-012 SHALL short-circuit specials from IDLE straight to DONE, 1-cycle latency, with this priority:
 - a or b exp=FF, or a=0 and b=0: quot=16'h7FC0, invalid=1.
 - b=0: quot={sign,8'hFF,7'h0}, div_by_zero=1.
 - a=0: quot={sign,15'h0}, no flag.
REQ-013 SHALL hold quot and flags stable in DONE until out_ready=1, then go to IDLE on that edge; in_valid is ignored outside IDLE.
REQ-014 SHALL have in_ready=0 on the DONE->IDLE edge cycle, so there is no same-cycle pass-through; a new operand can be accepted the cycle after.
REQ-015 SHALL keep flags at 0 except the bits set by REQ-010/012, and clear them on acceptance of new operands.

Reset
REQ-016 SHALL, when rst=1 at an edge, from any state including mid-DIV: state=IDLE, counter=0, q=0, quot=16'h0000, flags=4'h0, out_valid=0, in_ready=1 the following cycle; any in-flight result is discarded.
REQ-017 SHALL ignore in_valid while rst=1.

Structure
REQ-018 SHALL take the FSM state enum, BIAS, QNAN=16'h7FC0, EXP_MAX=8'hFF and flag bit indices from a shared package bf16_pkg.
REQ-019 SHALL place special-case classification (zero/inf/NaN detection, special result and flag selection) in one combinational sub-module, bf16_div_special.
REQ-020 SHALL fit in 120-400 RTL lines, with no multipliers or dividers inferred.

Verification
REQ-021 SHALL check 0x4000 / 0x3F80 (2.0/1.0) -> quot=0x4000, flags=0, out_valid exactly 10 cycles after accept.
REQ-022 SHALL check 0x3F80 / 0x4040 (1.0/3.0) -> quot=0x3EAA (truncated), NORM decrement path; and 0xC0C0 / 0x4000 (-6/2) -> quot=0xC040.
REQ-023 SHALL check 0x3F80 / 0x0000 -> quot=0x7F80, div_by_zero=1, 1-cycle latency; and 0x0000 / 0x0000 -> quot=0x7FC0, invalid=1.
REQ-024 SHALL check 0x7F00 / 0x3F00 -> quot=0x7F80, overflow=1; and 0x0080 / 0x4700 -> quot=0x0000, underflow=1.
REQ-025 SHALL check out_ready held low 5 cycles in DONE -> quot/flags stable, in_ready=0, new in_valid ignored; then 1 -> IDLE next edge.
REQ-026 SHALL check rst pulsed at DIV step 4 -> next cycle IDLE, out_valid=0, quot=0x0000, then 2.0/1.0 completes correctly.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared definitions for the sequential bfloat16 divider: FSM states, format
// constants, flag bit positions and small result-building helpers.
package bf16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          BIAS    = 127;
  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLAG_INVALID     = 3;
  localparam int FLAG_DIV_BY_ZERO = 2;
  localparam int FLAG_OVERFLOW    = 1;
  localparam int FLAG_UNDERFLOW   = 0;

  function automatic logic [15:0] signed_inf(input logic sign);
    return {sign, EXP_MAX, 7'h00};
  endfunction

  function automatic logic [15:0] signed_zero(input logic sign);
    return {sign, 15'h0000};
  endfunction

endpackage

// File: rtl/bf16_div_special.sv
// Combinational classifier for divider operands: detects zero/inf/NaN inputs
// and selects the short-circuit result and flags.
module bf16_div_special (
  input  logic [15:0] flp_a,
  input  logic [15:0] flp_b,
  output logic        is_special,
  output logic [15:0] spec_quot,
  output logic [3:0]  spec_flags
);
  import bf16_pkg::*;

  logic sign_s;
  logic a_zero_s;
  logic b_zero_s;
  logic a_nonfinite_s;
  logic b_nonfinite_s;

  assign sign_s        = flp_a[15] ^ flp_b[15];
  assign a_zero_s      = (flp_a[14:7] == 8'h00);
  assign b_zero_s      = (flp_b[14:7] == 8'h00);
  assign a_nonfinite_s = (flp_a[14:7] == EXP_MAX);
  assign b_nonfinite_s = (flp_b[14:7] == EXP_MAX);

  // Priority-ordered special result selection; mantissa of zero-exponent inputs is ignored
  always_comb begin
    is_special = 1'b0;
    spec_quot  = 16'h0000;
    spec_flags = 4'h0;
    if (a_nonfinite_s || b_nonfinite_s || (a_zero_s && b_zero_s)) begin
      is_special               = 1'b1;
      spec_quot                = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero_s) begin
      is_special                   = 1'b1;
      spec_quot                    = signed_inf(sign_s);
      spec_flags[FLAG_DIV_BY_ZERO] = 1'b1;
    end else if (a_zero_s) begin
      is_special = 1'b1;
      spec_quot  = signed_zero(sign_s);
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/bf16_div_seq.sv
// Sequential bfloat16 divider: restoring mantissa division one quotient bit
// per cycle, truncating normalisation, flush-to-zero and saturate-to-inf.
module bf16_div_seq #(
  parameter int BIAS = bf16_pkg::BIAS,
  parameter int ITER = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] flp_a,
  input  logic [15:0] flp_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quot,
  output logic [3:0]  flags
);
  import bf16_pkg::*;

  localparam logic signed [9:0] BIAS_S  = 10'(BIAS);
  localparam logic [3:0]        ITER_M1 = 4'(ITER - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                accept_s;
  logic                step_s;
  logic                norm_s;

  logic                sign_r;
  logic signed [9:0]   exp_tmp_r;
  logic [6:0]          mb_r;
  logic [8:0]          rem_r;
  logic [8:0]          q_r;
  logic [3:0]          cnt_r;
  logic [15:0]         quot_r;
  logic [3:0]          flags_r;

  logic                is_special_s;
  logic [15:0]         spec_quot_s;
  logic [3:0]          spec_flags_s;
  logic signed [9:0]   exp_calc_s;
  logic [8:0]          divisor_s;
  logic                ge_s;
  logic [7:0]          diff_s;
  logic [8:0]          rem_nxt_s;
  logic signed [9:0]   exp_adj_s;
  logic [6:0]          mant_s;
  logic [15:0]         norm_quot_s;
  logic [3:0]          norm_flags_s;

  bf16_div_special u_special (
    .flp_a      (flp_a),
    .flp_b      (flp_b),
    .is_special (is_special_s),
    .spec_quot  (spec_quot_s),
    .spec_flags (spec_flags_s)
  );

  assign exp_calc_s = $signed({2'b00, flp_a[14:7]}) - $signed({2'b00, flp_b[14:7]}) + BIAS_S;

  // Restoring step: remainder stays below twice the divisor, so 9 bits suffice
  assign divisor_s = {2'b01, mb_r};
  assign ge_s      = (rem_r >= divisor_s);
  assign diff_s    = rem_r[7:0] - divisor_s[7:0];
  assign rem_nxt_s = ge_s ? {diff_s, 1'b0} : {rem_r[7:0], 1'b0};

  // State register with registered handshake outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (is_special_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DIV;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == ITER_M1) begin
          state_nxt_s = NORM;
        end else begin
          state_nxt_s = DIV;
        end
      end
      NORM: state_nxt_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: datapath enables per state
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    norm_s   = 1'b0;
    case (state_r)
      IDLE:    accept_s = in_valid;
      DIV:     step_s   = 1'b1;
      NORM:    norm_s   = 1'b1;
      DONE:    accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
  end

  // Normalise the 9-bit quotient (truncating) and apply exponent range limits
  always_comb begin
    norm_quot_s  = 16'h0000;
    norm_flags_s = 4'h0;
    if (q_r[8]) begin
      exp_adj_s = exp_tmp_r;
      mant_s    = q_r[7:1];
    end else begin
      exp_adj_s = exp_tmp_r - 10'sd1;
      mant_s    = q_r[6:0];
    end
    if (exp_adj_s >= 10'sd255) begin
      norm_quot_s                 = signed_inf(sign_r);
      norm_flags_s[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_adj_s <= 10'sd0) begin
      norm_quot_s                  = signed_zero(sign_r);
      norm_flags_s[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      norm_quot_s = {sign_r, exp_adj_s[7:0], mant_s};
    end
  end

  // Datapath registers: operand capture, division steps, result update
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r    <= 1'b0;
      exp_tmp_r <= 10'sd0;
      mb_r      <= 7'h00;
      rem_r     <= 9'h000;
      q_r       <= 9'h000;
      cnt_r     <= 4'd0;
      quot_r    <= 16'h0000;
      flags_r   <= 4'h0;
    end else if (accept_s) begin
      sign_r    <= flp_a[15] ^ flp_b[15];
      exp_tmp_r <= exp_calc_s;
      mb_r      <= flp_b[6:0];
      rem_r     <= {2'b01, flp_a[6:0]};
      q_r       <= 9'h000;
      cnt_r     <= 4'd0;
      if (is_special_s) begin
        quot_r  <= spec_quot_s;
        flags_r <= spec_flags_s;
      end else begin
        flags_r <= 4'h0;
      end
    end else if (step_s) begin
      q_r   <= {q_r[7:0], ge_s};
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + 4'd1;
    end else if (norm_s) begin
      exp_tmp_r <= exp_adj_s;
      quot_r    <= norm_quot_s;
      flags_r   <= norm_flags_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quot      = quot_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Directed self-checking bench for bf16_div_seq with hand-computed results.
module tb_bf16_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] flp_a;
  logic [15:0] flp_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf16_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    flp_a    = a;
    flp_b    = b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts clock edges after the accepting edge; specials are ready on the accept edge itself
  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [3:0] f);
    check({tag, "_out_valid"}, {15'd0, out_valid}, 16'd1);
    check({tag, "_quot"}, quot, q);
    check({tag, "_flags"}, {12'd0, flags}, {12'd0, f});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, {15'd0, in_ready}, 16'd1);
    check({tag, "_idle_out_valid"}, {15'd0, out_valid}, 16'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [3:0] f, input int lat);
    start_op(tag, a, b);
    wait_result(tag, lat);
    check_result(tag, q, f);
    release_result(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    flp_a     = 16'h4000;
    flp_b     = 16'h3F80;
    repeat (3) tick();
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_quot", quot, 16'h0000);
    check("rst_flags", {12'd0, flags}, 16'h0000);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check("post_rst_idle", {15'd0, in_ready}, 16'd1);

    run_op("two_by_one",   16'h4000, 16'h3F80, 16'h4000, 4'b0000, 10);
    run_op("one_by_three", 16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 10);
    run_op("neg6_by_2",    16'hC0C0, 16'h4000, 16'hC040, 4'b0000, 10);
    run_op("div_zero",     16'h3F80, 16'h0000, 16'h7F80, 4'b0100, 0);
    run_op("zero_zero",    16'h0000, 16'h0000, 16'h7FC0, 4'b1000, 0);
    run_op("overflow",     16'h7F00, 16'h3F00, 16'h7F80, 4'b0010, 10);
    run_op("underflow",    16'h0080, 16'h4700, 16'h0000, 4'b0001, 10);
    run_op("negzero_by_2", 16'h8000, 16'h4000, 16'h8000, 4'b0000, 0);
    run_op("nan_a",        16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000, 0);
    run_op("inf_b",        16'h3F80, 16'h7F80, 16'h7FC0, 4'b1000, 0);
    run_op("neg_by_zero",  16'hBF80, 16'h0000, 16'hFF80, 4'b0100, 0);

    // Back-pressure: result must hold while new operands are offered and ignored
    start_op("hold", 16'h4000, 16'h3F80);
    wait_result("hold", 10);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      flp_a    = 16'h3F80;
      flp_b    = 16'h4040;
      tick();
      check("hold_quot", quot, 16'h4000);
      check("hold_flags", {12'd0, flags}, 16'h0000);
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      check("hold_out_valid", {15'd0, out_valid}, 16'd1);
    end
    in_valid = 1'b0;
    release_result("hold");
    tick();
    check("hold_stay_idle", {15'd0, in_ready}, 16'd1);
    check("hold_no_result", {15'd0, out_valid}, 16'd0);

    // Reset in the middle of the division discards the in-flight result
    start_op("mid_rst", 16'h3F80, 16'h4040);
    repeat (4) tick();
    check("mid_rst_busy", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_quot", quot, 16'h0000);
    check("mid_rst_flags", {12'd0, flags}, 16'h0000);
    repeat (12) tick();
    check("mid_rst_discarded", {15'd0, out_valid}, 16'd0);
    run_op("after_rst", 16'h4000, 16'h3F80, 16'h4000, 4'b0000, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
